// File: rtl/eth_frame_gen.sv
// Ethernet frame source for the MAC transmit byte interface: preamble, header, pattern payload, pad, CRC32 FCS.
// Optional FCS error injection is built only when ETH_FRAME_GEN_ERR_INJ_EN is defined.
module eth_frame_gen #(
    parameter int PAYLOAD_MAX = 1500,
    parameter int IFG_W       = 8,
    parameter bit PREAMBLE_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [47:0]      mac_dst,
    input  logic [47:0]      mac_src,
    input  logic [15:0]      ethertype,
    input  logic [15:0]      pay_len,
    input  logic             pay_mode,
    input  logic [7:0]       pay_seed,
    input  logic [15:0]      num_frames,
    input  logic [IFG_W-1:0] ifg_len,
    input  logic             err_inj,
    input  logic             tx_rdy,
    output logic [7:0]       mac_tx_data,
    output logic             mac_tx_valid,
    output logic             mac_tx_sof,
    output logic             mac_tx_eof,
    output logic             busy,
    output logic             done,
    output logic [31:0]      frames_sent
);
    localparam int          CW      = (IFG_W > 16) ? IFG_W : 16;
    localparam logic [15:0] LEN_MAX = 16'(PAYLOAD_MAX);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_PAY, S_PAD, S_FCS, S_IFG} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    crc_q, crc_d;
    logic [47:0]    dst_q, dst_d, src_q, src_d;
    logic [15:0]    type_q, type_d, len_q, len_d, num_q, num_d, run_q, run_d;
    logic           mode_q, mode_d, stop_q, stop_d, done_q, done_d;
    logic [7:0]     seed_q, seed_d;
    logic [IFG_W-1:0] ifg_q, ifg_d;
    logic [31:0]    sent_q, sent_d;

`ifdef ETH_FRAME_GEN_ERR_INJ_EN
    logic           err_q, err_d;
`else
    logic           unused_err_inj;
    assign unused_err_inj = err_inj;
`endif

    // Reflected (LSB-first) CRC32; complementing the register bytes LSB first gives the on-wire FCS.
    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 32'hEDB8_8320;
            else             c = c >> 1;
        end
        return c;
    endfunction

    logic [111:0] hdr_w;
    logic [7:0]   hdr_b [14];
    assign hdr_w = {dst_q, src_q, type_q};
    for (genvar gi = 0; gi < 14; gi++) begin : g_hdr
        assign hdr_b[gi] = hdr_w[111 - 8*gi -: 8];
    end

    logic [CW-1:0] len_ext, ifg_ext, ifg_last;
    logic [15:0]   len_clamp;
    logic          xfer;
    assign len_ext   = CW'(len_q);
    assign ifg_ext   = CW'(ifg_q);
    assign ifg_last  = (ifg_ext < CW'(12)) ? CW'(11) : ifg_ext - CW'(1);
    assign len_clamp = (pay_len > LEN_MAX) ? LEN_MAX : pay_len;
    assign xfer      = mac_tx_valid & tx_rdy;

    always_comb begin
        mac_tx_data  = 8'h00;
        mac_tx_valid = 1'b0;
        mac_tx_sof   = 1'b0;
        mac_tx_eof   = 1'b0;
        case (state_q)
            S_PRE: begin
                mac_tx_valid = 1'b1;
                mac_tx_data  = (cnt_q == CW'(7)) ? 8'hD5 : 8'h55;
                mac_tx_sof   = (cnt_q == '0);
            end
            S_HDR: begin
                mac_tx_valid = 1'b1;
                mac_tx_data  = hdr_b[cnt_q[3:0]];
                mac_tx_sof   = (cnt_q == '0) && !PREAMBLE_EN;
            end
            S_PAY: begin
                mac_tx_valid = 1'b1;
                mac_tx_data  = mode_q ? seed_q : seed_q + cnt_q[7:0];
            end
            S_PAD: mac_tx_valid = 1'b1;
            S_FCS: begin
                mac_tx_valid = 1'b1;
                mac_tx_eof   = (cnt_q == CW'(3));
                case (cnt_q[1:0])
                    2'd0:    mac_tx_data = ~crc_q[7:0];
                    2'd1:    mac_tx_data = ~crc_q[15:8];
                    2'd2:    mac_tx_data = ~crc_q[23:16];
                    default: mac_tx_data = ~crc_q[31:24];
                endcase
`ifdef ETH_FRAME_GEN_ERR_INJ_EN
                if (cnt_q == '0) mac_tx_data[0] = mac_tx_data[0] ^ err_q;
`endif
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        crc_d   = crc_q;
        dst_d   = dst_q;
        src_d   = src_q;
        type_d  = type_q;
        len_d   = len_q;
        mode_d  = mode_q;
        seed_d  = seed_q;
        num_d   = num_q;
        ifg_d   = ifg_q;
        run_d   = run_q;
        sent_d  = sent_q;
        done_d  = 1'b0;
        stop_d  = (state_q != S_IDLE) ? (stop_q | stop) : stop_q;
`ifdef ETH_FRAME_GEN_ERR_INJ_EN
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: if (start) begin
                state_d = PREAMBLE_EN ? S_PRE : S_HDR;
                cnt_d   = '0;
                crc_d   = 32'hFFFF_FFFF;
                dst_d   = mac_dst;
                src_d   = mac_src;
                type_d  = ethertype;
                len_d   = len_clamp;
                mode_d  = pay_mode;
                seed_d  = pay_seed;
                num_d   = num_frames;
                ifg_d   = ifg_len;
                run_d   = '0;
                stop_d  = stop;
            end
            S_PRE: if (xfer) begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(7)) begin
                    state_d = S_HDR;
                    cnt_d   = '0;
                end
            end
            S_HDR: if (xfer) begin
                crc_d = crc_byte(crc_q, mac_tx_data);
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(13)) begin
                    state_d = (len_q == '0) ? S_PAD : S_PAY;
                    cnt_d   = '0;
                end
            end
            S_PAY: if (xfer) begin
                crc_d = crc_byte(crc_q, mac_tx_data);
                cnt_d = cnt_q + CW'(1);
                // Short payloads keep counting into PAD so the pad ends at byte 46.
                if (cnt_q == len_ext - CW'(1)) begin
                    if (len_q >= 16'd46) begin
                        state_d = S_FCS;
                        cnt_d   = '0;
`ifdef ETH_FRAME_GEN_ERR_INJ_EN
                        err_d   = err_inj;
`endif
                    end else begin
                        state_d = S_PAD;
                    end
                end
            end
            S_PAD: if (xfer) begin
                crc_d = crc_byte(crc_q, mac_tx_data);
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(45)) begin
                    state_d = S_FCS;
                    cnt_d   = '0;
`ifdef ETH_FRAME_GEN_ERR_INJ_EN
                    err_d   = err_inj;
`endif
                end
            end
            S_FCS: if (xfer) begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(3)) begin
                    state_d = S_IFG;
                    cnt_d   = '0;
                    sent_d  = sent_q + 32'd1;
                    run_d   = run_q + 16'd1;
                end
            end
            S_IFG: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == ifg_last) begin
                    cnt_d = '0;
                    if (stop_q || stop || (num_q != '0 && run_q == num_q)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = PREAMBLE_EN ? S_PRE : S_HDR;
                        crc_d   = 32'hFFFF_FFFF;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            crc_q   <= 32'hFFFF_FFFF;
            dst_q   <= '0;
            src_q   <= '0;
            type_q  <= '0;
            len_q   <= '0;
            mode_q  <= 1'b0;
            seed_q  <= '0;
            num_q   <= '0;
            ifg_q   <= '0;
            run_q   <= '0;
            sent_q  <= '0;
            stop_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ETH_FRAME_GEN_ERR_INJ_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            dst_q   <= dst_d;
            src_q   <= src_d;
            type_q  <= type_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            seed_q  <= seed_d;
            num_q   <= num_d;
            ifg_q   <= ifg_d;
            run_q   <= run_d;
            sent_q  <= sent_d;
            stop_q  <= stop_d;
            done_q  <= done_d;
`ifdef ETH_FRAME_GEN_ERR_INJ_EN
            err_q   <= err_d;
`endif
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign frames_sent = sent_q;
endmodule
